// File: rtl/sram_like_if.sv
// sram-like data interface: request/accept channel plus in-order response.
interface sram_like_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_stall;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, wstrb, addr, wdata, addr_stall,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, wstrb, addr, wdata, addr_stall,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_like_resp.sv
// Responder end of the sram-like data interface: word RAM with byte-strobed
// writes, reads snapshotted at acceptance, and fixed-latency in-order data_ok.
module sram_like_resp #(
   parameter int AW      = 10,
   parameter int LATENCY = 2,
   parameter int QDEPTH  = 2
) (
   input  logic        clk,
   input  logic        reset,
   sram_like_if.slave  bus
);
   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);
   // An entry leaves the queue on the edge that raises data_ok, one cycle
   // before its age would reach LATENCY.
   localparam logic [3:0] POP_AGE = 4'(LATENCY - 1);
   localparam logic [3:0] MAX_AGE = 4'(LATENCY);

   logic [31:0]       mem [0:(1 << AW) - 1];

   logic [QDEPTH-1:0] q_vld_r;
   logic [QDEPTH-1:0] q_rd_r;
   logic [31:0]       q_data_r [QDEPTH];
   logic [3:0]        q_age_r  [QDEPTH];
   logic [PW-1:0]     wr_ptr_r;
   logic [PW-1:0]     rd_ptr_r;
   logic [CW-1:0]     count_r;

   logic              data_ok_r;
   logic [31:0]       rdata_r;

   logic [AW-1:0]     idx_s;
   logic              accept_s;
   logic              push_s;
   logic              pop_s;
   logic              resp_s;
   logic              resp_rd_s;
   logic [31:0]       resp_data_s;
   logic              unused_s;

   // Advance a circular-queue pointer modulo QDEPTH.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(QDEPTH - 1)) begin
         return '0;
      end else begin
         return p + PW'(1);
      end
   endfunction

   assign idx_s    = bus.addr[AW+1:2];
   assign unused_s = ^{bus.size, bus.addr[31:AW+2], bus.addr[1:0]};

   // Acceptance ignores req and any same-cycle pop.
   assign bus.addr_ok = !reset && !bus.addr_stall && (count_r < CW'(QDEPTH));
   assign accept_s    = bus.req && bus.addr_ok;

   assign bus.data_ok = data_ok_r;
   assign bus.rdata   = rdata_r;

   // Select push/pop and the response source; LATENCY==1 answers straight from acceptance.
   always_comb begin
      push_s      = 1'b0;
      pop_s       = 1'b0;
      resp_s      = 1'b0;
      resp_rd_s   = 1'b0;
      resp_data_s = 32'd0;
      if (LATENCY == 1) begin
         resp_s      = accept_s;
         resp_rd_s   = !bus.wr;
         resp_data_s = mem[idx_s];
      end else begin
         push_s      = accept_s;
         pop_s       = q_vld_r[rd_ptr_r] && (q_age_r[rd_ptr_r] == POP_AGE);
         resp_s      = pop_s;
         resp_rd_s   = q_rd_r[rd_ptr_r];
         resp_data_s = q_data_r[rd_ptr_r];
      end
   end

   // Commit accepted writes byte by byte; the RAM is never cleared by reset.
   always_ff @(posedge clk) begin
      if (accept_s && bus.wr) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.wstrb[b]) begin
               mem[idx_s][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
         end
      end
   end

   // Outstanding-request queue: age entries, pop the head, push new requests.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_vld_r  <= '0;
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         for (int i = 0; i < QDEPTH; i++) begin
            if (q_vld_r[i] && (q_age_r[i] < MAX_AGE)) begin
               q_age_r[i] <= q_age_r[i] + 4'd1;
            end
         end
         if (pop_s) begin
            q_vld_r[rd_ptr_r] <= 1'b0;
            rd_ptr_r          <= ptr_inc(rd_ptr_r);
         end
         if (push_s) begin
            q_vld_r[wr_ptr_r]  <= 1'b1;
            q_rd_r[wr_ptr_r]   <= !bus.wr;
            q_data_r[wr_ptr_r] <= mem[idx_s];
            q_age_r[wr_ptr_r]  <= 4'd1;
            wr_ptr_r           <= ptr_inc(wr_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Registered response pulse; rdata is 0 for writes and holds between responses.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_ok_r <= 1'b0;
         rdata_r   <= 32'd0;
      end else begin
         data_ok_r <= resp_s;
         if (resp_s) begin
            rdata_r <= resp_rd_s ? resp_data_s : 32'd0;
         end else begin
            rdata_r <= rdata_r;
         end
      end
   end
endmodule

// File: tb/tb_sram_like_resp.sv
// Bench for sram_like_resp: two instances (LATENCY 2 and 4, QDEPTH 2) share
// one stimulus stream and are checked every cycle against a request-list model.
module tb_sram_like_resp;
   logic clk;
   logic reset;

   sram_like_if if2 ();
   sram_like_if if4 ();

   sram_like_resp #(.AW(10), .LATENCY(2), .QDEPTH(2)) d2 (
      .clk(clk), .reset(reset), .bus(if2.slave));
   sram_like_resp #(.AW(10), .LATENCY(4), .QDEPTH(2)) d4 (
      .clk(clk), .reset(reset), .bus(if4.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          k;
      int          due;
      bit          rd;
      logic [31:0] data;
      bit          chk;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] mm [2][1024];
   bit          wn [2][1024];
   logic [31:0] lrd [2];
   bit          lknown [2];
   int          cyc;
   int          checks;
   int          errors;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   // Reference behaviour of instance k for the current cycle.
   task automatic model_step(input int k, input logic r, input logic w, input logic [3:0] s,
                             input logic [31:0] a, input logic [31:0] d, input logic st,
                             input logic rs);
      int          lat;
      int          cnt;
      int          h;
      bit          exp_ok;
      bit          exp_dok;
      logic        ok_o;
      logic        dok_o;
      logic [31:0] rd_o;
      int          idx;
      lat   = (k == 0) ? 2 : 4;
      ok_o  = (k == 0) ? if2.addr_ok : if4.addr_ok;
      dok_o = (k == 0) ? if2.data_ok : if4.data_ok;
      rd_o  = (k == 0) ? if2.rdata : if4.rdata;
      cnt = 0;
      h   = -1;
      for (int i = 0; i < mq.size(); i++) begin
         if (mq[i].k == k) begin
            if (h < 0) h = i;
            if (mq[i].due > cyc) cnt++;
         end
      end
      exp_ok  = !rs && !st && (cnt < 2);
      exp_dok = (h >= 0) && (mq[h].due == cyc);
      check($sformatf("addr_ok[L%0d]", lat), {31'd0, ok_o}, {31'd0, exp_ok});
      check($sformatf("data_ok[L%0d]", lat), {31'd0, dok_o}, {31'd0, exp_dok});
      if (exp_dok) begin
         lrd[k]    = mq[h].rd ? mq[h].data : 32'd0;
         lknown[k] = !mq[h].rd || mq[h].chk;
         mq.delete(h);
      end
      if (lknown[k]) check($sformatf("rdata[L%0d]", lat), rd_o, lrd[k]);
      if (rs) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].k == k) mq.delete(i);
         end
         lrd[k]    = 32'd0;
         lknown[k] = 1'b1;
      end else if (r && exp_ok) begin
         idx = int'(a[11:2]);
         mq.push_back('{k: k, due: cyc + lat, rd: !w, data: mm[k][idx], chk: wn[k][idx]});
         if (w) begin
            for (int b = 0; b < 4; b++) begin
               if (s[b]) mm[k][idx][8*b +: 8] = d[8*b +: 8];
            end
            if (s == 4'hF) wn[k][idx] = 1'b1;
         end
      end
   endtask

   // One clock cycle: drive inputs, check at the falling edge, advance.
   task automatic tick(input logic r, input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, input logic st, input logic rs);
      if2.req = r; if2.wr = w; if2.wstrb = s; if2.addr = a; if2.wdata = d;
      if2.addr_stall = st; if2.size = 2'd2;
      if4.req = r; if4.wr = w; if4.wstrb = s; if4.addr = a; if4.wdata = d;
      if4.addr_stall = st; if4.size = 2'd2;
      reset = rs;
      @(negedge clk);
      model_step(0, r, w, s, a, d, st, rs);
      model_step(1, r, w, s, a, d, st, rs);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic wr_gap(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      tick(1'b1, 1'b1, s, a, d, 1'b0, 1'b0);
      idle(1);
   endtask

   task automatic rd_now(input logic [31:0] a);
      tick(1'b1, 1'b0, 4'h0, a, 32'd0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] ra;
      logic [3:0]  rs4;
      checks = 0;
      errors = 0;
      cyc    = 0;
      for (int k = 0; k < 2; k++) begin
         lrd[k]    = 32'd0;
         lknown[k] = 1'b1;
         for (int i = 0; i < 1024; i++) wn[k][i] = 1'b0;
      end
      reset = 1'b1;
      if2.req = 1'b0; if2.wr = 1'b0; if2.wstrb = 4'h0; if2.addr = 32'd0; if2.wdata = 32'd0;
      if2.addr_stall = 1'b0; if2.size = 2'd0;
      if4.req = 1'b0; if4.wr = 1'b0; if4.wstrb = 4'h0; if4.addr = 32'd0; if4.wdata = 32'd0;
      if4.addr_stall = 1'b0; if4.size = 2'd0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state, with a request pending that must not be accepted.
      tick(1'b1, 1'b0, 4'h0, 32'h0, 32'd0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 4'h0, 32'h0, 32'd0, 1'b0, 1'b1);
      idle(2);

      // Fill words 0..63 so every later read has a known value.
      for (int i = 0; i < 64; i++) wr_gap(32'(i * 4), 4'hF, $urandom);
      idle(4);

      // Single read.
      wr_gap(32'h40, 4'hF, 32'hDEADBEEF);
      idle(3);
      rd_now(32'h40);
      idle(6);
      check("single_read_L2", if2.rdata, 32'hDEADBEEF);
      check("single_read_L4", if4.rdata, 32'hDEADBEEF);

      // Strobed writes then read.
      wr_gap(32'h80, 4'hF, 32'h11223344);
      wr_gap(32'h80, 4'b0100, 32'h00AA0000);
      rd_now(32'h80);
      idle(6);
      check("strobe_read_L2", if2.rdata, 32'h11AA3344);
      check("strobe_read_L4", if4.rdata, 32'h11AA3344);

      // Empty-strobe write changes nothing but still responds.
      wr_gap(32'h80, 4'h0, 32'hFFFFFFFF);
      rd_now(32'h80);
      idle(6);
      check("zero_strobe_L2", if2.rdata, 32'h11AA3344);

      // Back-to-back reads.
      rd_now(32'h0); rd_now(32'h4); rd_now(32'h8); rd_now(32'hC);
      idle(6);

      // Request held high: full queue on the LATENCY 4 instance.
      for (int i = 0; i < 12; i++) rd_now(32'($urandom_range(0, 63) * 4));
      idle(6);

      // Stall with req high, then release.
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 4'h0, 32'h40, 32'd0, 1'b1, 1'b0);
      rd_now(32'h44);
      idle(6);

      // Aliasing: upper address bits are ignored.
      wr_gap(32'h1000_0040, 4'hF, 32'hCAFEF00D);
      rd_now(32'h40);
      idle(6);
      check("alias_L2", if2.rdata, 32'hCAFEF00D);
      check("alias_L4", if4.rdata, 32'hCAFEF00D);

      // Reset mid-flight: outstanding reads dropped, RAM contents kept.
      rd_now(32'h0);
      rd_now(32'h4);
      tick(1'b0, 1'b0, 4'h0, 32'h0, 32'd0, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 4'h0, 32'h8, 32'd0, 1'b0, 1'b1);
      idle(6);
      rd_now(32'h40);
      idle(6);
      check("after_reset_L2", if2.rdata, 32'hCAFEF00D);
      check("after_reset_L4", if4.rdata, 32'hCAFEF00D);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         ra  = {$urandom_range(0, 15) == 0 ? 20'($urandom) : 20'd0, 4'd0,
                6'($urandom_range(0, 63)), 2'($urandom)};
         rs4 = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
         tick($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rs4, ra, $urandom,
              $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
      end
      idle(8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
